// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer with EX/MEM/WB scoreboard, hazard stalls, flush and freeze; forwarding/bypass only when HAZARD_CTRL_FWD_EN is defined.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_wr,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  ex_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  id_byp_a,
    output logic                  id_byp_b,
    output logic [CNT_W-1:0]      stall_cnt
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_wr;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } entry_t;

    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FREEZE = 2'd3;

    logic [1:0] state, state_nxt;
    entry_t     sb [0:2];
    entry_t     id_entry;
    logic       live, go, flush, stall, hazard;

    function automatic logic hit(input entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid && e.reg_wr && (e.rd != '0) && (e.rd == r);
    endfunction

    always_comb begin
        id_entry.valid   = id_valid && !id_ex_bubble;
        id_entry.rd      = id_rd;
        id_entry.reg_wr  = id_reg_wr;
        id_entry.is_load = id_is_load;
        id_entry.rs1     = id_rs1;
        id_entry.rs2     = id_rs2;
        id_entry.use_rs1 = id_use_rs1;
        id_entry.use_rs2 = id_use_rs2;
    end

`ifdef HAZARD_CTRL_FWD_EN
    assign hazard = id_valid && sb[0].is_load &&
                    ((id_use_rs1 && hit(sb[0], id_rs1)) || (id_use_rs2 && hit(sb[0], id_rs2)));
    assign fwd_a_sel = !(sb[0].valid && sb[0].use_rs1) ? 2'b00 :
                       hit(sb[1], sb[0].rs1) ? 2'b01 : hit(sb[2], sb[0].rs1) ? 2'b10 : 2'b00;
    assign fwd_b_sel = !(sb[0].valid && sb[0].use_rs2) ? 2'b00 :
                       hit(sb[1], sb[0].rs2) ? 2'b01 : hit(sb[2], sb[0].rs2) ? 2'b10 : 2'b00;
    assign id_byp_a  = id_use_rs1 && hit(sb[2], id_rs1);
    assign id_byp_b  = id_use_rs2 && hit(sb[2], id_rs2);
`else
    // Without forwarding a consumer waits until its producer has left WB.
    assign hazard = id_valid &&
                    ((id_use_rs1 && (hit(sb[0], id_rs1) || hit(sb[1], id_rs1) || hit(sb[2], id_rs1))) ||
                     (id_use_rs2 && (hit(sb[0], id_rs2) || hit(sb[1], id_rs2) || hit(sb[2], id_rs2))));
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign id_byp_a  = 1'b0;
    assign id_byp_b  = 1'b0;
`endif

    // FREEZE with mem_busy low already evaluates like RUN, so a freeze costs exactly the busy cycles.
    assign live  = (state == S_RUN) || (state == S_FREEZE);
    assign go    = (state == S_FILL) || (live && !mem_busy);
    assign flush = live && !mem_busy && ex_branch_taken;
    assign stall = live && !mem_busy && !ex_branch_taken && hazard;

    assign if_en        = go && !stall;
    assign id_en        = go && !stall;
    assign ex_en        = go;
    assign mem_en       = go;
    assign wb_en        = go;
    assign id_ex_bubble = flush || stall;
    assign if_id_flush  = flush;

    always_comb
        state_nxt = (state == S_RESET) ? S_FILL :
                    (state == S_FILL)  ? S_RUN  :
                    mem_busy           ? S_FREEZE : S_RUN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RESET;
            stall_cnt <= '0;
            for (int i = 0; i < 3; i++) sb[i] <= '0;
        end else begin
            state <= state_nxt;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_en) sb[0] <= id_entry;
            if (mem_en) sb[1] <= sb[0];
            if (wb_en) sb[2] <= sb[1];
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of reset/fill, data hazards, flush, freeze, x0 and async reset for hazard_ctrl.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_busy;
    logic       if_en, id_en, ex_en, mem_en, wb_en, id_ex_bubble, if_id_flush, id_byp_a, id_byp_b;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int cnt_exp = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    wire [4:0] en  = {if_en, id_en, ex_en, mem_en, wb_en};
    wire [1:0] ctl = {id_ex_bubble, if_id_flush};
    wire [3:0] fwd = {fwd_a_sel, fwd_b_sel};
    wire [1:0] byp = {id_byp_a, id_byp_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_reg_wr = wr; id_is_load = ld;
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) begin step(); nop(); end
    endtask

    task automatic stall_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) step();
            #1;
            chk({tag, "_en"}, 32'(en), 32'h07);
            chk({tag, "_ctl"}, 32'(ctl), 32'h2);
        end
        cnt_exp += n;
    endtask

    initial begin
        rst = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        nop();
        step(); step(); #1;
        chk("rst_en", 32'(en), 32'h00);
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_fwd", 32'(fwd), 32'h0);
        chk("rst_byp", 32'(byp), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        // release, with a branch pending so FILL and RUN are distinguishable
        rst = 1'b1; ex_branch_taken = 1'b1; #1;
        chk("reset_hold_en", 32'(en), 32'h00);
        step(); #1;
        chk("fill_en", 32'(en), 32'h1f);
        chk("fill_ctl", 32'(ctl), 32'h0);
        step(); #1;
        chk("run_flush_ctl", 32'(ctl), 32'h3);
        chk("run_flush_en", 32'(en), 32'h1f);
        ex_branch_taken = 1'b0; #1;
        chk("run_idle_ctl", 32'(ctl), 32'h0);
        chk("run_cnt", 32'(stall_cnt), 32'd0);
        drain();

        // add x5,x1,x2 ; sub x6,x5,x3
        step(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); #1;
        chk("A_add_en", 32'(en), 32'h1f);
        step(); id_set(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
`ifdef HAZARD_CTRL_FWD_EN
        #1 chk("A_nostall_en", 32'(en), 32'h1f);
        step(); nop(); #1;
        chk("A_fwd_mem", 32'(fwd), 32'h4);
        drain();
        // add x5 ; nop ; sub x6,x5,x3 ; reader of x5 in ID while add is in WB
        step(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        step(); nop();
        step(); id_set(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0); #1;
        chk("A2_nostall_en", 32'(en), 32'h1f);
        step(); id_set(1, 5'd9, 1, 5'd5, 1, 5'd7, 1, 0); #1;
        chk("A2_fwd_wb", 32'(fwd), 32'h8);
        chk("A2_byp", 32'(byp), 32'h1);
`else
        stall_run("A_stall", 3);
        step(); #1;
        chk("A_go_en", 32'(en), 32'h1f);
        chk("A_cnt", 32'(stall_cnt), 32'(cnt_exp));
`endif
        drain();

        // lw x5,0(x1) ; add x6,x5,x5
        step(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        step(); id_set(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
`ifdef HAZARD_CTRL_FWD_EN
        stall_run("B_lu", 1);
        step(); #1;
        chk("B_go_en", 32'(en), 32'h1f);
        step(); nop(); #1;
        chk("B_fwd_wb", 32'(fwd), 32'ha);
`else
        stall_run("B_stall", 3);
        step(); #1;
        chk("B_go_en", 32'(en), 32'h1f);
`endif
        chk("B_cnt", 32'(stall_cnt), 32'(cnt_exp));
        drain();

        // branch taken in the same cycle as a load-use hazard
        step(); id_set(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1);
        step(); id_set(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0); ex_branch_taken = 1'b1; #1;
        chk("C_flush_ctl", 32'(ctl), 32'h3);
        chk("C_flush_en", 32'(en), 32'h1f);
        step(); nop(); ex_branch_taken = 1'b0; #1;
        chk("C_after_en", 32'(en), 32'h1f);
        chk("C_cnt", 32'(stall_cnt), 32'(cnt_exp));
        drain();

        // mem_busy for 3 cycles
        step(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        step(); id_set(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
`ifdef HAZARD_CTRL_FWD_EN
        step(); nop();
`endif
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            #1;
            chk("D_frz_en", 32'(en), 32'h00);
            chk("D_frz_ctl", 32'(ctl), 32'h0);
`ifdef HAZARD_CTRL_FWD_EN
            chk("D_frz_fwd", 32'(fwd), 32'h4);
`endif
        end
        step(); mem_busy = 1'b0;
`ifdef HAZARD_CTRL_FWD_EN
        #1 chk("D_resume_en", 32'(en), 32'h1f);
        chk("D_resume_fwd", 32'(fwd), 32'h4);
        step(); #1;
        chk("D_next_fwd", 32'(fwd), 32'h0);
`else
        stall_run("D_rel", 3);
        step(); #1;
        chk("D_go_en", 32'(en), 32'h1f);
`endif
        chk("D_cnt", 32'(stall_cnt), 32'(cnt_exp));
        drain();

        // writes to x0 never create a dependency
        step(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        step(); id_set(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0); #1;
        chk("E_nostall_en", 32'(en), 32'h1f);
        step(); id_set(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0); #1;
        chk("E_en", 32'(en), 32'h1f);
        chk("E_fwd0", 32'(fwd), 32'h0);
        step(); #1;
        chk("E_byp0", 32'(byp), 32'h0);
        chk("E_cnt", 32'(stall_cnt), 32'(cnt_exp));
        drain();

        // asynchronous reset mid-cycle while a dependency is in flight
        step(); id_set(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        step(); id_set(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("F_rst_en", 32'(en), 32'h00);
        chk("F_rst_ctl", 32'(ctl), 32'h0);
        chk("F_rst_cnt", 32'(stall_cnt), 32'd0);
        step(); rst = 1'b1; nop(); #1;
        chk("F_hold_en", 32'(en), 32'h00);
        step(); #1;
        chk("F_fill_en", 32'(en), 32'h1f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). Replaces the single global `pipeline_advance` with per-stage enables and bubble/flush controls. Tracks destination registers in flight in an internal scoreboard and drives the EX-operand forwarding selects. Detects load-use and branch hazards and freezes the pipeline on data-memory wait.

## Interface
- `REG_ADDR_W`, default 5: register address width.
- `CNT_W`, default 16: width of the stall counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source register addresses in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction actually reads that source.
- `id_rd`  in  REG_ADDR_W  destination register of the ID instruction.
- `id_reg_wr`  in  1  the ID instruction writes `id_rd`.
- `id_is_load`  in  1  the ID instruction is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `mem_busy`  in  1  data memory not ready; freeze the pipeline.
- `if_en`, `id_en`, `ex_en`, `mem_en`, `wb_en`  out  1  pipeline register write enables: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- `id_ex_bubble`  out  1  load a NOP (all control zero) into ID/EX.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `fwd_a_sel`, `fwd_b_sel`  out  2  EX operand source: 00 = register file, 01 = `ALU_PP` (MEM), 10 = `RD_DATA` (WB).
- `id_byp_a`, `id_byp_b`  out  1  ID read equals the WB write this cycle; select `RD_DATA` for that read.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `if_en` = 0 in RUN.

## Operation
- Scoreboard: three entries, EX/MEM/WB. Each entry holds {valid, rd, reg_wr, is_load, rs1, rs2, use_rs1, use_rs2}.
- Scoreboard advance, when the corresponding enable is high:
  - ID fields shift into EX. They enter as invalid when `id_ex_bubble` is high or `id_valid` is low.
  - EX shifts into MEM, and MEM shifts into WB.
- A register match requires valid, reg_wr, and rd ≠ 0. x0 never matches.
- FSM states:
  - RESET: held while `rst` is low. All enables 0 and the scoreboard invalid. Exits to FILL on the first clock after deassertion.
  - FILL: one cycle with all enables 1 and no hazard checks. Then goes to RUN.
  - RUN: normal hazard evaluation.
  - FREEZE: entered while `mem_busy` = 1. All enables 0; scoreboard, fwd selects and bypasses hold their values. Returns to RUN on the first cycle with `mem_busy` = 0.
- Priority in RUN, highest first: `mem_busy` (go to FREEZE), flush, load-use, none.
- Flush (`ex_branch_taken` = 1):
  - Assert `if_id_flush` and `id_ex_bubble`.
  - All enables stay 1; the PC loads the target.
  - Flush overrides a simultaneous load-use stall.
- Load-use: `id_valid`, the EX entry is a load, and an ID source it uses matches EX rd.
  - `if_en` = `id_en` = 0, `id_ex_bubble` = 1; the other enables stay 1.
  - Stall lasts exactly one cycle, after which the load sits in MEM and forwards from WB.
- Forwarding, for the EX entry's rs1 and rs2 independently: MEM match gives 01, else WB match gives 10, else 00. MEM wins when both match.
- ID bypass: `id_byp_x` = WB match on the ID source that is used.
- `stall_cnt` increments on load-use stall cycles and saturates at all-ones.

## Timing
- Reset values: all enables 0, `id_ex_bubble` 0, `if_id_flush` 0, fwd selects 00, bypasses 0, `stall_cnt` 0, scoreboard invalid.
- These outputs are combinational from current state, scoreboard and inputs, with zero-cycle latency:
  - all enables
  - `id_ex_bubble` and `if_id_flush`
  - fwd selects and bypasses
- Scoreboard and FSM update on the same edge as the pipeline registers they mirror.
- Branch penalty is 2 cycles; load-use penalty is 1 cycle.
- `mem_busy` asserted together with a branch or load-use: FREEZE wins, and the hazard is re-evaluated after release.
- `rst` low mid-operation: outputs go to reset values immediately (asynchronous) and the scoreboard is cleared.

## Configuration
- `HAZARD_CTRL_FWD_EN` defined: forwarding and bypass logic as described above.
- Not defined: fwd selects and bypasses tied to 0. Any used ID source matching EX, MEM or WB stalls as a load-use stall does, repeating until the producer retires. Branch and freeze behaviour is unchanged.

## Test plan
- Reset release: `rst` low→high → enables 0 in RESET, exactly one FILL cycle, then RUN; `stall_cnt` = 0.
- `add x5,x1,x2` then `sub x6,x5,x3` → no stall; `fwd_a_sel` = 01 when sub is in EX. Insert one NOP between them → `fwd_a_sel` = 10.
- `lw x5,0(x1)` then `add x6,x5,x5` → one cycle with `if_en` = `id_en` = 0 and `id_ex_bubble` = 1, then `fwd_a_sel` = `fwd_b_sel` = 10; `stall_cnt` = 1.
- `ex_branch_taken` = 1 in the same cycle as a load-use hazard → `if_id_flush` = `id_ex_bubble` = 1, `if_en` = 1, no stall counted.
- `mem_busy` high for 3 cycles during a forwarding case → all enables 0 for 3 cycles, fwd selects unchanged, normal flow resumes.
- Writes to x0 followed by a read of x0 → fwd selects 00 and bypasses 0. With `HAZARD_CTRL_FWD_EN` undefined, the `add x5`/`sub x6` pair stalls 3 cycles.
